// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding and default
// starvation settings.
package data_memory_arbiter_pkg;

   typedef enum logic [1:0] {
      S_CPU       = 2'd0,
      S_DBG_ISSUE = 2'd1,
      S_DBG_DONE  = 2'd2
   } arb_state_t;

   localparam int DEFAULT_STARVE_LIMIT = 4;
   localparam int DEFAULT_COUNT_WIDTH  = 3;

endpackage

// File: rtl/data_memory_arbiter_starve_counter.sv
// Saturating up-counter with synchronous clear; flags when the limit is hit.
module arb_starve_counter #(
   parameter int COUNT_WIDTH = 3,
   parameter int LIMIT       = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   increment,
   output logic [COUNT_WIDTH-1:0] count,
   output logic                   limit_reached
);

   localparam logic [COUNT_WIDTH-1:0] LIMIT_C = COUNT_WIDTH'(LIMIT);

   assign limit_reached = (count == LIMIT_C);

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (increment && !limit_reached) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the data_memory port between the MEM stage (default owner) and a
// debug/loader port that borrows it for two cycles per access.
module data_memory_arbiter
   import data_memory_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
   parameter int COUNT_WIDTH  = DEFAULT_COUNT_WIDTH
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   cpu_request,
   input  logic                   cpu_write,
   input  logic [ADDR_WIDTH-1:0]  cpu_address,
   input  logic [DATA_WIDTH-1:0]  cpu_write_data,
   output logic [DATA_WIDTH-1:0]  cpu_read_data,
   output logic                   cpu_stall,
   input  logic                   dbg_request,
   input  logic                   dbg_write,
   input  logic [ADDR_WIDTH-1:0]  dbg_address,
   input  logic [DATA_WIDTH-1:0]  dbg_write_data,
   output logic                   dbg_ack,
   output logic [DATA_WIDTH-1:0]  dbg_read_data,
   output logic [ADDR_WIDTH-1:0]  mem_address,
   output logic [DATA_WIDTH-1:0]  mem_write_data,
   output logic                   mem_write_enable,
   input  logic [DATA_WIDTH-1:0]  mem_read_data,
   output arb_state_t             debug_state,
   output logic [COUNT_WIDTH-1:0] debug_starve_count
);

   arb_state_t            state_q, state_next, cur_state;
   logic                  grant, limit_reached, count_inc, count_clr;
   logic                  lat_write;
   logic [ADDR_WIDTH-1:0] lat_address;
   logic [DATA_WIDTH-1:0] lat_write_data;

   // The unused encoding 3 behaves exactly like S_CPU.
   always_comb begin
      cur_state = S_CPU;
      if (state_q == S_DBG_ISSUE || state_q == S_DBG_DONE) cur_state = state_q;
   end

   always_comb begin
      state_next       = S_CPU;
      grant            = 1'b0;
      dbg_ack          = 1'b0;
      mem_address      = cpu_address;
      mem_write_data   = cpu_write_data;
      mem_write_enable = cpu_request & cpu_write;
      case (cur_state)
         S_CPU: begin
            if (dbg_request && (!cpu_request || limit_reached)) begin
               grant      = 1'b1;
               state_next = S_DBG_ISSUE;
            end
         end
         S_DBG_ISSUE: begin
            mem_address      = lat_address;
            mem_write_data   = lat_write_data;
            mem_write_enable = lat_write;
            state_next       = S_DBG_DONE;
         end
         S_DBG_DONE: begin
            mem_address      = lat_address;
            mem_write_data   = lat_write_data;
            mem_write_enable = 1'b0;
            dbg_ack          = 1'b1;
         end
         default: ;
      endcase
   end

   assign cpu_read_data      = mem_read_data;
   assign cpu_stall          = cpu_request & (cur_state != S_CPU);
   assign count_inc          = (cur_state == S_CPU) & dbg_request & cpu_request & ~grant;
   assign count_clr          = grant | ~dbg_request;
   assign debug_state        = state_q;

   arb_starve_counter #(
      .COUNT_WIDTH (COUNT_WIDTH),
      .LIMIT       (STARVE_LIMIT)
   ) u_starve (
      .clock         (clock),
      .reset         (reset),
      .clear         (count_clr),
      .increment     (count_inc),
      .count         (debug_starve_count),
      .limit_reached (limit_reached)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= S_CPU;
         lat_write      <= 1'b0;
         lat_address    <= '0;
         lat_write_data <= '0;
         dbg_read_data  <= '0;
      end else begin
         state_q <= state_next;
         if (grant) begin
            lat_write      <= dbg_write;
            lat_address    <= dbg_address;
            lat_write_data <= dbg_write_data;
         end
         // Memory runs on ~clock, so its read data is ready by this edge.
         if (cur_state == S_DBG_ISSUE && !lat_write) dbg_read_data <= mem_read_data;
      end
   end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: vector table, directed corner sequences and
// a randomized run against a cycle-level reference of the sharing rules.
module tb_data_memory_arbiter;
   import data_memory_arbiter_pkg::*;

   localparam int LIMIT = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        cpu_request, cpu_write;
   logic [31:0] cpu_address, cpu_write_data, cpu_read_data;
   logic        cpu_stall;
   logic        dbg_request, dbg_write;
   logic [31:0] dbg_address, dbg_write_data, dbg_read_data;
   logic        dbg_ack;
   logic [31:0] mem_address, mem_write_data;
   logic        mem_write_enable;
   logic [31:0] mem_read_data = '0;
   arb_state_t  debug_state;
   logic [2:0]  debug_starve_count;

   int total = 0;
   int bad   = 0;

   logic [31:0] tb_mem  [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];

   typedef struct {
      logic        req;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_we;
      logic        chk_rd;
      logic [31:0] exp_rd;
   } vec_t;
   vec_t vecs [8];

   data_memory_arbiter #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(LIMIT), .COUNT_WIDTH(3)
   ) dut (
      .clock(clock), .reset(reset),
      .cpu_request(cpu_request), .cpu_write(cpu_write), .cpu_address(cpu_address),
      .cpu_write_data(cpu_write_data), .cpu_read_data(cpu_read_data), .cpu_stall(cpu_stall),
      .dbg_request(dbg_request), .dbg_write(dbg_write), .dbg_address(dbg_address),
      .dbg_write_data(dbg_write_data), .dbg_ack(dbg_ack), .dbg_read_data(dbg_read_data),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data),
      .debug_state(debug_state), .debug_starve_count(debug_starve_count)
   );

   // clock / reset
   always #5 clock = ~clock;

   // data_memory stand-in, clocked on the falling edge, write-first
   always @(negedge clock) begin
      if (mem_write_enable) tb_mem[mem_address] = mem_write_data;
      mem_read_data <= tb_mem.exists(mem_address) ? tb_mem[mem_address] : 32'h0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #7;
   endtask

   task automatic idle_inputs();
      cpu_request = 0; cpu_write = 0; cpu_address = 0; cpu_write_data = 0;
      dbg_request = 0; dbg_write = 0; dbg_address = 0; dbg_write_data = 0;
   endtask

   task automatic dbg_drive(input logic wr, input logic [31:0] a, input logic [31:0] d);
      dbg_request = 1; dbg_write = wr; dbg_address = a; dbg_write_data = d;
   endtask

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
   endfunction

   function automatic logic [31:0] rand_addr();
      return 32'h100 + 32'($urandom_range(0, 7)) * 4;
   endfunction

   initial begin
      int ack_cnt, stall_cnt, first_stall, ack_at [$];
      int m_phase, m_wait;
      logic m_wr, prev_ack, e_stall, e_ack, e_we;
      logic [31:0] m_addr, m_wd, m_rd, e_addr, e_wd;

      vecs[0] = '{1, 1, 32'h40, 32'h1111_2222, 1, 0, 32'h0};
      vecs[1] = '{1, 0, 32'h40, 32'h0,         0, 1, 32'h1111_2222};
      vecs[2] = '{0, 1, 32'h40, 32'h0000_0099, 0, 0, 32'h0};
      vecs[3] = '{1, 0, 32'h40, 32'h0,         0, 1, 32'h1111_2222};
      vecs[4] = '{1, 1, 32'h44, 32'h3333_4444, 1, 0, 32'h0};
      vecs[5] = '{1, 0, 32'h44, 32'h0,         0, 1, 32'h3333_4444};
      vecs[6] = '{1, 1, 32'h40, 32'h5555_6666, 1, 0, 32'h0};
      vecs[7] = '{1, 0, 32'h40, 32'h0,         0, 1, 32'h5555_6666};

      // 1: reset held two cycles with every request high
      reset = 1; idle_inputs();
      cpu_request = 1; cpu_write = 1; dbg_request = 1; dbg_write = 1;
      next_cycle(); next_cycle(); settle();
      chk("rst_state", 32'(debug_state), 32'(S_CPU));
      chk("rst_stall", 32'(cpu_stall), 0);
      chk("rst_ack", 32'(dbg_ack), 0);
      chk("rst_dbg_rd", dbg_read_data, 0);
      chk("rst_count", 32'(debug_starve_count), 0);
      next_cycle(); reset = 0; idle_inputs();
      next_cycle();

      // CPU pass-through vectors
      foreach (vecs[i]) begin
         cpu_request = vecs[i].req; cpu_write = vecs[i].wr;
         cpu_address = vecs[i].addr; cpu_write_data = vecs[i].wdata;
         settle();
         chk($sformatf("vec%0d_we", i), 32'(mem_write_enable), 32'(vecs[i].exp_we));
         chk($sformatf("vec%0d_addr", i), mem_address, vecs[i].addr);
         chk($sformatf("vec%0d_stall", i), 32'(cpu_stall), 0);
         if (vecs[i].chk_rd) chk($sformatf("vec%0d_rd", i), cpu_read_data, vecs[i].exp_rd);
         next_cycle();
      end
      idle_inputs();

      // 2: uncontended DBG write
      ack_cnt = 0;
      dbg_drive(1, 32'h10, 32'hDEAD_BEEF);
      for (int i = 0; i < 5; i++) begin
         settle();
         chk($sformatf("t2_we_c%0d", i), 32'(mem_write_enable), (i == 1) ? 1 : 0);
         chk($sformatf("t2_ack_c%0d", i), 32'(dbg_ack), (i == 2) ? 1 : 0);
         if (i == 1) begin
            chk("t2_addr", mem_address, 32'h10);
            chk("t2_wdata", mem_write_data, 32'hDEAD_BEEF);
         end
         next_cycle();
         if (i == 2) dbg_request = 0;
      end
      cpu_request = 1; cpu_write = 0; cpu_address = 32'h10;
      settle();
      chk("t2_cpu_load", cpu_read_data, 32'hDEAD_BEEF);
      next_cycle(); idle_inputs();

      // 3: uncontended DBG read, result held afterwards
      dbg_drive(0, 32'h10, 32'h0);
      next_cycle(); next_cycle(); settle();
      chk("t3_ack", 32'(dbg_ack), 1);
      chk("t3_rd", dbg_read_data, 32'hDEAD_BEEF);
      next_cycle(); dbg_request = 0;
      next_cycle(); next_cycle(); settle();
      chk("t3_rd_held", dbg_read_data, 32'hDEAD_BEEF);
      next_cycle();

      // 4: continuous CPU traffic forces the DBG grant after LIMIT cycles
      stall_cnt = 0; first_stall = -1; ack_at.delete();
      cpu_request = 1; cpu_write = 0; cpu_address = 32'h44;
      dbg_drive(0, 32'h10, 32'h0);
      for (int i = 0; i < 9; i++) begin
         if (i == 7) dbg_request = 0;
         settle();
         if (i < 5) chk($sformatf("t4_count_c%0d", i), 32'(debug_starve_count), 32'(i));
         if (cpu_stall) begin
            stall_cnt++;
            if (first_stall < 0) first_stall = i;
         end
         if (dbg_ack) ack_at.push_back(i);
         if (i == 5) chk("t4_count_cleared", 32'(debug_starve_count), 0);
         next_cycle();
      end
      chk("t4_stall_cycles", 32'(stall_cnt), 2);
      chk("t4_first_stall", 32'(first_stall), 5);
      chk("t4_ack_count", 32'(ack_at.size()), 1);
      if (ack_at.size() > 0) chk("t4_ack_cycle", 32'(ack_at[0]), 6);
      idle_inputs();
      next_cycle();

      // 5: reset during S_DBG_ISSUE of a DBG write
      dbg_drive(1, 32'h20, 32'hCAFE_F00D);
      next_cycle(); settle();
      chk("t5_in_issue", 32'(debug_state), 32'(S_DBG_ISSUE));
      reset = 1; dbg_request = 0;
      next_cycle(); reset = 0; settle();
      chk("t5_state", 32'(debug_state), 32'(S_CPU));
      chk("t5_no_ack0", 32'(dbg_ack), 0);
      next_cycle(); settle();
      chk("t5_no_ack1", 32'(dbg_ack), 0);
      next_cycle();
      cpu_request = 1; cpu_write = 0; cpu_address = 32'h20;
      settle();
      chk("t5_mem_written", cpu_read_data, 32'hCAFE_F00D);
      next_cycle(); idle_inputs();

      // 6: dbg_request left high after ack starts a second access
      ack_at.delete();
      dbg_drive(0, 32'h40, 32'h0);
      for (int i = 0; i < 9; i++) begin
         if (i == 6) dbg_request = 0;
         settle();
         if (dbg_ack) ack_at.push_back(i);
         if (i == 3) chk("t6_gap_state", 32'(debug_state), 32'(S_CPU));
         next_cycle();
      end
      chk("t6_ack_count", 32'(ack_at.size()), 2);
      if (ack_at.size() == 2) chk("t6_ack_spacing", 32'(ack_at[1] - ack_at[0]), 3);

      // randomized run against the reference
      reset = 1; idle_inputs();
      next_cycle(); reset = 0;
      m_phase = 0; m_wait = 0; m_wr = 0; m_addr = 0; m_wd = 0; m_rd = 0; prev_ack = 0;
      for (int c = 0; c < 3000; c++) begin
         reset          = ($urandom_range(0, 149) == 0);
         cpu_request    = 1'($urandom_range(0, 1));
         cpu_write      = 1'($urandom_range(0, 1));
         cpu_address    = rand_addr();
         cpu_write_data = $urandom();
         if (dbg_request && prev_ack) begin
            if ($urandom_range(0, 3) != 0) dbg_request = 0;
         end else if (!dbg_request && $urandom_range(0, 2) == 0) begin
            dbg_drive(1'($urandom_range(0, 1)), rand_addr(), $urandom());
         end
         settle();

         e_stall = cpu_request && (m_phase != 0);
         e_ack   = (m_phase == 2);
         if (m_phase == 0) begin
            e_we = cpu_request && cpu_write; e_addr = cpu_address; e_wd = cpu_write_data;
         end else begin
            e_we = (m_phase == 1) && m_wr; e_addr = m_addr; e_wd = m_wd;
         end
         chk("rnd_stall", 32'(cpu_stall), 32'(e_stall));
         chk("rnd_ack", 32'(dbg_ack), 32'(e_ack));
         chk("rnd_we", 32'(mem_write_enable), 32'(e_we));
         chk("rnd_addr", mem_address, e_addr);
         if (e_we) chk("rnd_wdata", mem_write_data, e_wd);
         if (m_phase == 0 && cpu_request && !cpu_write) chk("rnd_cpu_rd", cpu_read_data, ref_read(cpu_address));
         chk("rnd_dbg_rd", dbg_read_data, m_rd);
         chk("rnd_state", 32'(debug_state), 32'(m_phase));
         chk("rnd_count", 32'(debug_starve_count), 32'(m_wait));
         prev_ack = e_ack;

         if (e_we) ref_mem[e_addr] = e_wd;
         if (reset) begin
            m_phase = 0; m_wait = 0; m_rd = 0; m_wr = 0; m_addr = 0; m_wd = 0;
         end else if (m_phase == 0) begin
            if (dbg_request && (!cpu_request || m_wait == LIMIT)) begin
               m_phase = 1; m_wait = 0;
               m_wr = dbg_write; m_addr = dbg_address; m_wd = dbg_write_data;
            end else if (dbg_request) begin
               m_wait = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
            end else begin
               m_wait = 0;
            end
         end else if (m_phase == 1) begin
            if (!m_wr) m_rd = ref_read(m_addr);
            m_phase = 2;
         end else begin
            m_phase = 0;
         end
         next_cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
